mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder: serves CPU accesses from internal HRAM / IE register or
// forwards them to an external port with an ack timeout.
module mem_responder #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        bus_err,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_wait_cnt;
    logic [DW-1:0]   r_ie;
    logic [DW-1:0]   r_hram [0:126];

    logic            r_cpu_ready;
    logic            r_bus_err;
    logic            r_ext_req;
    logic            r_ext_we;
    logic [DW-1:0]   r_cpu_rdata;

    logic            w_capture;
    logic            w_hit_int;
    logic            w_hit_ie;
    logic            w_tmo;
    logic            w_cpu_ready_nxt;
    logic            w_bus_err_nxt;
    logic            w_ext_req_nxt;
    logic            w_ext_we_nxt;
    logic [DW-1:0]   w_cpu_rdata_nxt;
    logic [CW-1:0]   w_wait_cnt_nxt;
    logic            w_ie_we;
    logic            w_hram_we;

    assign w_capture = (r_state == ST_IDLE) && cpu_req;
    assign w_hit_int = (cpu_addr[15:7] == 9'h1FF);
    assign w_hit_ie  = (cpu_addr == 16'hFFFF);
    assign w_tmo     = (r_wait_cnt == TMO_LAST);

    // State, capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= '0;
            r_ie        <= '0;
            r_cpu_ready <= 1'b0;
            r_bus_err   <= 1'b0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_cpu_ready <= w_cpu_ready_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_ext_req   <= w_ext_req_nxt;
            r_ext_we    <= w_ext_we_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            if (w_capture) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (w_ie_we) begin
                r_ie <= cpu_wdata;
            end
        end
    end

    // HRAM storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_hram_we) begin
            r_hram[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cpu_req) w_state_nxt = w_hit_int ? ST_RESP : ST_EXT;
            ST_EXT:  if (ext_ack || w_tmo) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of outputs, counter and internal storage strobes
    always_comb begin
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_bus_err_nxt   = 1'b0;
        w_cpu_ready_nxt = (w_state_nxt == ST_RESP);
        w_ext_req_nxt   = (w_state_nxt == ST_EXT);
        w_ext_we_nxt    = 1'b0;
        w_wait_cnt_nxt  = '0;
        w_ie_we         = 1'b0;
        w_hram_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ext_we_nxt = (w_state_nxt == ST_EXT) && cpu_we;
                if (cpu_req && w_hit_int) begin
                    if (cpu_we) begin
                        w_ie_we   = w_hit_ie;
                        w_hram_we = !w_hit_ie && !rst;
                    end else begin
                        w_cpu_rdata_nxt = w_hit_ie ? r_ie : r_hram[cpu_addr[6:0]];
                    end
                end
            end
            ST_EXT: begin
                w_ext_we_nxt = (w_state_nxt == ST_EXT) && r_we;
                if (ext_ack) begin
                    if (!r_we) w_cpu_rdata_nxt = ext_rdata;
                end else if (w_tmo) begin
                    if (!r_we) w_cpu_rdata_nxt = 8'hFF;
                    w_bus_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = r_cpu_ready;
    assign bus_err   = r_bus_err;
    assign ext_req   = r_ext_req;
    assign ext_we    = r_ext_we;
    assign ext_addr  = r_addr;
    assign ext_wdata = r_wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever cpu_ready is seen.
module tb_mem_responder;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        bus_err;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = '0;
    logic        ext_ack = 1'b0;

    mem_responder #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .bus_err(bus_err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: memory contents and the last value cpu_rdata should hold
    logic [7:0] m_hram [0:126];
    bit         m_valid [0:126];
    logic [7:0] m_ie = 8'h00;
    logic [7:0] m_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (cpu_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: cpu_ready=1 with no access outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.rdata});
                check("bus_err", {31'h0, bus_err}, {31'h0, e.err});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0; ext_ack = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", {31'h0, cpu_ready}, 0);
        check("rst_bus_err", {31'h0, bus_err}, 0);
        check("rst_ext_req", {31'h0, ext_req}, 0);
        check("rst_cpu_rdata", {24'h0, cpu_rdata}, 0);
        rst = 1'b0;
        m_ie = 8'h00;
        m_rdata = 8'h00;
    endtask

    task automatic int_access(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        exp_t e;
        int idx;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; ext_ack = 1'b0;
        idx = int'(addr) - 32'hFF80;
        if (addr == 16'hFFFF) begin
            if (we) m_ie = wd; else m_rdata = m_ie;
        end else begin
            if (we) begin m_hram[idx] = wd; m_valid[idx] = 1'b1; end
            else m_rdata = m_hram[idx];
        end
        e.rdata = m_rdata; e.err = 1'b0; e.cyc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        check("int_no_ext_req", {31'h0, ext_req}, 0);
        cpu_req = 1'b0;
    endtask

    // k: ext_req cycle (0-based) on which ack is driven; negative = never
    task automatic ext_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              input int k, input logic [7:0] rd);
        exp_t e;
        bit   ack_hit;
        int   last;
        int   hi_cnt;
        int   t;
        ack_hit = (k >= 0) && (k < TMO);
        last = ack_hit ? k : TMO - 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; ext_ack = 1'b0;
        t = cyc;
        if (!we) m_rdata = ack_hit ? rd : 8'hFF;
        e.rdata = m_rdata; e.err = !ack_hit; e.cyc = t + 2 + last;
        q.push_back(e);
        hi_cnt = 0;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (ext_req === 1'b1) hi_cnt++;
            if (i == 0 || i == last) begin
                check("ext_addr", {16'h0, ext_addr}, {16'h0, addr});
                check("ext_we", {31'h0, ext_we}, {31'h0, we});
                if (we) check("ext_wdata", {24'h0, ext_wdata}, {24'h0, wd});
            end
            ext_ack = (i == k);
            ext_rdata = (i == k) ? rd : 8'($urandom);
        end
        @(negedge clk);
        check("ext_req_drop", {31'h0, ext_req}, 0);
        check("ext_req_cycles", hi_cnt, last + 1);
        ext_ack = 1'($urandom_range(0, 1));
        ext_rdata = 8'($urandom);
        cpu_req = 1'b0;
    endtask

    task automatic reset_mid_ext();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000; ext_ack = 1'b0;
        @(negedge clk);
        check("rx_ext_req_1", {31'h0, ext_req}, 1);
        @(negedge clk);
        check("rx_ext_req_2", {31'h0, ext_req}, 1);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("rx_ext_req_after_rst", {31'h0, ext_req}, 0);
        rst = 1'b0;
        m_ie = 8'h00; m_rdata = 8'h00;
        ext_ack = 1'b1; ext_rdata = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rx_late_ack_ext_req", {31'h0, ext_req}, 0);
            check("rx_late_ack_rdata", {24'h0, cpu_rdata}, 0);
        end
        ext_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 127; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        check("init_cpu_ready", {31'h0, cpu_ready}, 0);
        check("init_ext_req", {31'h0, ext_req}, 0);
        check("init_cpu_rdata", {24'h0, cpu_rdata}, 0);
        rst = 1'b0;

        // HRAM round trip and IE reset behaviour
        int_access(1'b1, 16'hFF80, 8'h5A);
        int_access(1'b0, 16'hFF80, 8'h00);
        int_access(1'b1, 16'hFFFF, 8'h1F);
        int_access(1'b0, 16'hFFFF, 8'h00);
        do_reset();
        int_access(1'b0, 16'hFFFF, 8'h00);
        int_access(1'b1, 16'hFFFE, 8'hC3);
        int_access(1'b0, 16'hFFFE, 8'h00);

        // External ack, timeout, coincident ack+timeout, external write
        ext_access(1'b0, 16'hC000, 8'h00, 2, 8'h3C);
        ext_access(1'b0, 16'h8000, 8'h00, -1, 8'h00);
        ext_access(1'b0, 16'h8000, 8'h00, TMO - 1, 8'h77);
        ext_access(1'b1, 16'h1234, 8'h99, 0, 8'h00);
        ext_access(1'b1, 16'hFF7F, 8'h42, -1, 8'h00);
        reset_mid_ext();

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            int r;
            logic we;
            logic [15:0] a;
            int idx;
            r = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            if (r <= 3) begin
                idx = $urandom_range(0, 126);
                if (!m_valid[idx]) we = 1'b1;
                int_access(we, 16'(32'hFF80 + idx), 8'($urandom));
            end else if (r == 4) begin
                int_access(we, 16'hFFFF, 8'($urandom));
            end else begin
                int m;
                int k;
                a = 16'($urandom);
                while (a >= 16'hFF80) a = 16'($urandom);
                m = $urandom_range(0, 5);
                k = (m == 0) ? -1 : (m == 1) ? TMO - 1 : $urandom_range(0, 6);
                ext_access(we, a, 8'($urandom), k, 8'($urandom));
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time (checks %0d, failures %0d)", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
